icache_fetch_ctrl: RTL and testbench

Fetch-side controller for the instruction cache. It owns a direct-mapped tag/valid/data array and accepts PC fetch requests from the pipeline. Hits return the instruction one cycle after acceptance, matching the existing registered icache read. Misses stall the pipeline while the controller refills the whole line from backing instruction memory over a req/ack handshake.

---
 rtl/icache_fetch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_icache_fetch_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_fetch_ctrl
// Description : Direct-mapped instruction cache fetch controller. A hit
//               returns its word one cycle after acceptance. A miss stalls
//               the pipeline while the whole line is refilled from backing
//               memory over a req/ack handshake.
// Option      : ICACHE_PERF_CNT_EN adds saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_fetch_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_stall,
  output logic        fetch_valid,
  output logic [31:0] fetch_data,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        data_mem [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0]   tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic               flush_pending;

  // Miss bookkeeping latched at acceptance
  logic [TAG_W-1:0]   fill_tag;
  logic [IDX_W-1:0]   fill_idx;
  logic [OFF_W-1:0]   fill_off;
  logic [OFF_W-1:0]   beat;

  logic [OFF_W-1:0]   req_off;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic               accept;
  logic               last_beat;
  logic               unused_addr_lsbs;

  assign req_off   = fetch_addr[OFF_W+1:2];
  assign req_idx   = fetch_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign req_tag   = fetch_addr[31:OFF_W+IDX_W+2];
  assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign last_beat = (beat == LAST_BEAT);

  // Any pending flush blocks new requests until the valid bits are cleared
  assign fetch_stall = (state != IDLE) | flush | flush_pending;
  assign accept      = fetch_req & ~fetch_stall;

  // Byte-lane bits are meaningless for word fetches
  assign unused_addr_lsbs = &{1'b0, fetch_addr[1:0]};

  // Refill beats land in the data array; tag is written with the last beat
  always_ff @(posedge clk) begin
    if (rst_n && (state == REFILL) && mem_ack) begin
      data_mem[{fill_idx, beat}] <= mem_rdata;
      if (last_beat) begin
        tag_mem[fill_idx] <= fill_tag;
      end
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      valid         <= '0;
      flush_pending <= 1'b0;
      fetch_valid   <= 1'b0;
      fetch_data    <= 32'd0;
      mem_req       <= 1'b0;
      mem_addr      <= 32'd0;
      fill_tag      <= '0;
      fill_idx      <= '0;
      fill_off      <= '0;
      beat          <= '0;
    end else begin
      fetch_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            valid <= '0;
          end else if (accept) begin
            if (hit) begin
              fetch_valid <= 1'b1;
              fetch_data  <= data_mem[{req_idx, req_off}];
            end else begin
              fill_tag <= req_tag;
              fill_idx <= req_idx;
              fill_off <= req_off;
              beat     <= '0;
              mem_req  <= 1'b1;
              mem_addr <= {fetch_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
              state    <= REFILL;
            end
          end
        end
        REFILL: begin
          if (flush) begin
            flush_pending <= 1'b1;
          end
          if (mem_ack) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              valid[fill_idx] <= 1'b1;
              mem_req         <= 1'b0;
              fetch_valid     <= 1'b1;
              // The final beat is still in flight to the array, so bypass it
              fetch_data      <= (fill_off == LAST_BEAT) ? mem_rdata
                                                         : data_mem[{fill_idx, fill_off}];
              state           <= RESPOND;
            end else begin
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        RESPOND: begin
          if (flush || flush_pending) begin
            valid <= '0;
          end
          flush_pending <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Saturating hit/miss counters over accepted requests
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else if (accept) begin
      if (hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_fetch_ctrl
// Description : Self-checking bench for icache_fetch_ctrl with a 2-cycle
//               latency memory model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_fetch_ctrl;

  localparam int LW = 4;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_stall;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        flush;
  logic        flush_tb;
  logic        flush_mem;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  assign flush = flush_tb | flush_mem;

  icache_fetch_ctrl #(.LINE_WORDS(LW), .NUM_LINES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int resp_cnt = 0;
  int ack_cnt = 0;
  int flush_beat = -1;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [31:0] sb[$];
  logic [31:0] addrq[$];

  typedef struct {
    logic [31:0] addr;
    bit          hit;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h20:  return 32'h2003_0006;
      32'h24:  return 32'h2004_0008;
      32'h28:  return 32'h2005_0009;
      32'h2C:  return 32'h1483_0004;
      default: return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction

  // Backing memory: acks each beat two cycles after it is presented
  initial begin
    int cnt = 0;
    int bil = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    flush_mem = 1'b0;
    forever begin
      @(negedge clk);
      flush_mem = 1'b0;
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = mem_req ? 1 : 0;
      end else if (mem_req && rst_n) begin
        cnt++;
        if (cnt >= 2) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          addrq.push_back(mem_addr);
          ack_cnt++;
          if (bil == flush_beat) flush_mem = 1'b1;
          bil++;
        end
      end else begin
        cnt = 0;
        bil = 0;
      end
    end
  end

  // Scoreboard: every fetch_valid pulse must match the oldest expected word
  initial begin
    forever begin
      @(negedge clk);
      if (fetch_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", fetch_data, 32'hxxxx_xxxx);
        end else begin
          chk("fetch_data", fetch_data, sb.pop_front());
        end
        resp_cnt++;
      end
    end
  end

  // Single fetch: called and returns just after a rising edge
  task automatic do_fetch(input logic [31:0] addr, input bit exp_hit);
    int n0 = resp_cnt;
    int a0 = ack_cnt;
    int cyc = 0;
    bit stall_bad = 1'b0;
    logic [31:0] base;
    addrq.delete();
    fetch_req  = 1'b1;
    fetch_addr = addr;
    @(negedge clk);
    chk("stall_idle", {31'd0, fetch_stall}, 32'd0);
    sb.push_back(mem_word(addr));
    if (exp_hit) exp_hits++; else exp_misses++;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    while (resp_cnt == n0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (resp_cnt == n0 && !fetch_stall) stall_bad = 1'b1;
    end
    chk("resp_timeout", {31'd0, (resp_cnt == n0)}, 32'd0);
    chk("beats", ack_cnt - a0, exp_hit ? 0 : LW);
    if (exp_hit) begin
      chk("hit_latency", cyc, 1);
    end else begin
      chk("stall_miss", {31'd0, stall_bad}, 32'd0);
      base = {addr[31:4], 4'h0};
      for (int i = 0; i < LW && i < addrq.size(); i++) begin
        chk("mem_addr", addrq[i], base + 32'(4 * i));
      end
    end
    chk("mem_req_idle", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    int n0;
    int a0;
    int cyc;
    vecs[0] = '{32'h000, 1'b0};
    vecs[1] = '{32'h02C, 1'b0};
    vecs[2] = '{32'h004, 1'b1};
    vecs[3] = '{32'h02C, 1'b1};
    vecs[4] = '{32'h120, 1'b0};
    vecs[5] = '{32'h124, 1'b1};
    vecs[6] = '{32'h020, 1'b0};
    vecs[7] = '{32'h008, 1'b1};
    vecs[8] = '{32'h1FC, 1'b0};
    vecs[9] = '{32'h1F0, 1'b1};

    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 32'd0;
    flush_tb   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_fetch_stall", {31'd0, fetch_stall}, 32'd0);
    chk("rst_fetch_data", fetch_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      do_fetch(vecs[i].addr, vecs[i].hit);
    end

    // Back-to-back hits on the refilled line
    n0 = resp_cnt;
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 32'h20 + 32'(4 * i);
      @(negedge clk);
      chk("b2b_stall", {31'd0, fetch_stall}, 32'd0);
      sb.push_back(mem_word(fetch_addr));
      exp_hits++;
      @(posedge clk); #1;
      chk("b2b_resp_count", resp_cnt - n0, i);
      chk("b2b_mem_req", {31'd0, mem_req}, 32'd0);
    end
    fetch_req = 1'b0;
    @(posedge clk); #1;
    chk("b2b_resp_count", resp_cnt - n0, 3);

    // Flush on beat-1 ack: response still arrives, line is then invalid
    flush_beat = 1;
    do_fetch(32'h12C, 1'b0);
    flush_beat = -1;
    do_fetch(32'h12C, 1'b0);
    do_fetch(32'h000, 1'b0);

    // Flush in IDLE blocks a simultaneous request and invalidates line 0
    fetch_req  = 1'b1;
    fetch_addr = 32'h000;
    flush_tb   = 1'b1;
    @(negedge clk);
    chk("flush_idle_stall", {31'd0, fetch_stall}, 32'd1);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    flush_tb  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_fetch(32'h000, 1'b0);

`ifdef ICACHE_PERF_CNT_EN
    chk("hit_cnt", hit_cnt, exp_hits);
    chk("miss_cnt", miss_cnt, exp_misses);
`endif

    // Reset after beat 2 aborts the refill
    a0 = ack_cnt;
    fetch_req  = 1'b1;
    fetch_addr = 32'h02C;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    cyc = 0;
    while ((ack_cnt - a0) < 3 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_mid_beats", ack_cnt - a0, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_valid", {31'd0, fetch_valid}, 32'd0);
    rst_n = 1'b1;
    sb.delete();
    exp_hits   = 0;
    exp_misses = 0;
    @(posedge clk); #1;
`ifdef ICACHE_PERF_CNT_EN
    chk("hit_cnt_rst", hit_cnt, 32'd0);
    chk("miss_cnt_rst", miss_cnt, 32'd0);
`endif
    do_fetch(32'h02C, 1'b0);
    do_fetch(32'h028, 1'b1);
`ifdef ICACHE_PERF_CNT_EN
    chk("hit_cnt_end", hit_cnt, exp_hits);
    chk("miss_cnt_end", miss_cnt, exp_misses);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
